mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-to-one memory-port arbiter directly downstream of the multicycle MIPS core. It takes the core's instruction-fetch channel and its data load/store channel, serialises them onto one single-port memory bus, and returns read data to whichever channel issued the request. Only one transaction is outstanding at a time. Requests are registered at acceptance, so core-side address and data may change once ready has been returned.

## Interface
No parameters. Clock clk; reset rst, synchronous, active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req_valid  in  1  fetch request from core
- inst_addr  in  32  fetch address (core PC)
- inst_req_ready  out  1  fetch request accepted this cycle
- inst_valid  out  1  fetch data valid
- inst_ready  in  1  core accepts fetch data
- inst_data  out  32  fetched instruction
- d_read  in  1  data load request
- d_write  in  1  data store request
- d_addr  in  32  data address (word aligned by core)
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte strobes
- d_req_ready  out  1  data request accepted this cycle
- d_rdata_valid  out  1  load data valid
- d_rdata_ready  in  1  core accepts load data
- d_rdata  out  32  load data
- m_req_valid  out  1  memory request valid
- m_req_ready  in  1  memory accepts request
- m_addr  out  32  memory address
- m_we  out  1  1 = write, 0 = read
- m_wdata  out  32  write data
- m_wstrb  out  4  write strobes; 4'b0000 on reads
- m_resp_valid  in  1  read data valid; writes produce no response
- m_resp_ready  out  1  arbiter accepts read data
- m_resp_data  in  32  read data

## Operation
- FSM states: IDLE, MREQ, MRESP, RET.
- **IDLE**
  - Arbitrates between fetch (inst_req_valid) and data (d_read|d_write).
  - The granted channel's ready is asserted combinationally in the same cycle.
  - On that handshake, register src (inst/data), addr, we, wdata and wstrb; go to MREQ.
- **Request decoding**
  - d_write && d_read both high: treated as a write. The read is dropped and is not retried.
  - Fetch requests: we=0, wstrb=0.
- **MREQ**
  - Drive m_req_valid=1 with the registered fields until m_req_ready.
  - On handshake: writes go to IDLE; reads go to MRESP.
- **MRESP**
  - m_resp_ready=1.
  - On m_resp_valid, capture m_resp_data into the src-selected output register (inst_data or d_rdata); go to RET.
- **RET**
  - Assert inst_valid or d_rdata_valid per src.
  - Hold until the matching ready, then go to IDLE.
- inst_data and d_rdata hold their last value outside RET.
- Default arbitration is fixed priority: data over fetch.
- All upstream readies are 0 outside IDLE. No request is accepted while a transaction is in flight.

## Timing
- **Reset:** state=IDLE. Registered outputs clear: inst_valid=0, d_rdata_valid=0, m_req_valid=0, m_resp_ready=0, m_addr=0, m_we=0, m_wdata=0, m_wstrb=0, inst_data=0, d_rdata=0.
- **Readies during reset:** the combinational readies inst_req_ready and d_req_ready are forced 0 while rst=1.
- **Reset mid-transaction:** the transaction is abandoned. No valid is asserted afterwards, and a late m_resp_valid in IDLE is ignored (m_resp_ready=0).
- **Read latency** with zero-wait memory: accept at cycle 0, m_req handshake at cycle 1, m_resp at cycle 2, upstream valid at cycle 3.
- **Write:** accept at cycle 0, m_req handshake at cycle 1, IDLE again at cycle 2. The next accept is possible at cycle 2.
- **Memory-side stalls:** m_req_ready and m_resp_valid may stay low indefinitely. Registered fields must remain stable while m_req_valid=1 && !m_req_ready.
- **Upstream back-pressure:** inst_ready or d_rdata_ready held low keeps the FSM in RET with the data stable.

## Configuration
- **Macro MEM_ARB_RR_EN defined:** round-robin arbitration.
  - A 1-bit last_grant register updates on every accept.
  - When both channels request in IDLE, the grant goes to the channel not granted last.
  - last_grant resets to "data", so fetch wins the first simultaneous contest.
- **Macro not defined:** fixed priority (data over fetch); the register is not instantiated.

## Test plan
- **Fetch:** inst_req_valid with inst_addr=0x100, memory returns 0x24020005 on the first cycle -> m_addr=0x100, m_we=0; inst_valid=1 with inst_data=0x24020005 exactly 3 cycles after accept.
- **Store:** d_write, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, m_req_ready held low 4 cycles -> m_req_valid held with fields stable; return to IDLE 1 cycle after the handshake; no d_rdata_valid.
- **Simultaneous requests, fixed priority:** d_read plus fetch in the same cycle -> data granted first. With MEM_ARB_RR_EN, the first grant is fetch; repeating the contest after completion grants data.
- **Load back-pressure:** load, d_rdata_ready low 5 cycles -> d_rdata_valid and d_rdata stay stable; no new accept until the handshake.
- **Reset in MRESP:** assert rst during MRESP, then memory raises m_resp_valid with 0x1234 -> data ignored; both valids 0; d_rdata=0.
- **Read and write both high:** d_read=d_write=1 -> single write on the bus with m_we=1; no read response is generated.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter: serialises MIPS fetch and load/store channels onto one memory bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_valid,
  input  logic [31:0] inst_addr,
  output logic        inst_req_ready,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_req_ready,
  output logic        d_rdata_valid,
  input  logic        d_rdata_ready,
  output logic [31:0] d_rdata,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_resp_valid,
  output logic        m_resp_ready,
  input  logic [31:0] m_resp_data
);

  typedef enum logic [1:0] {IDLE, MREQ, MRESP, RET} state_e;
  typedef enum logic {SRC_INST, SRC_DATA} src_e;

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic d_any;
  logic grant_data;
  logic accept;

  assign d_any = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  src_e last_grant_q, last_grant_d;

  // On contention, the channel not granted last time wins.
  always_comb begin
    if (d_any && inst_req_valid) grant_data = (last_grant_q == SRC_INST);
    else                         grant_data = d_any;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = grant_data ? SRC_DATA : SRC_INST;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= SRC_DATA;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign grant_data = d_any;
`endif

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    addr_d         = addr_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    inst_data_d    = inst_data_q;
    d_rdata_d      = d_rdata_q;
    inst_req_ready = 1'b0;
    d_req_ready    = 1'b0;
    accept         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rst && (d_any || inst_req_valid)) begin
          accept  = 1'b1;
          state_d = MREQ;
          if (grant_data) begin
            d_req_ready = 1'b1;
            src_d       = SRC_DATA;
            addr_d      = d_addr;
            // A simultaneous read and write collapses to the write alone.
            we_d        = d_write;
            wdata_d     = d_write ? d_wdata : '0;
            wstrb_d     = d_write ? d_wstrb : '0;
          end else begin
            inst_req_ready = 1'b1;
            src_d          = SRC_INST;
            addr_d         = inst_addr;
            we_d           = 1'b0;
            wdata_d        = '0;
            wstrb_d        = '0;
          end
        end
      end
      MREQ: begin
        if (m_req_ready) state_d = we_q ? IDLE : MRESP;
      end
      MRESP: begin
        if (m_resp_valid) begin
          state_d = RET;
          if (src_q == SRC_INST) inst_data_d = m_resp_data;
          else                   d_rdata_d   = m_resp_data;
        end
      end
      RET: begin
        if ((src_q == SRC_INST) ? inst_ready : d_rdata_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= SRC_INST;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      inst_data_q <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      inst_data_q <= inst_data_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign m_req_valid   = (state_q == MREQ);
  assign m_resp_ready  = (state_q == MRESP);
  assign m_addr        = addr_q;
  assign m_we          = we_q;
  assign m_wdata       = wdata_q;
  assign m_wstrb       = wstrb_q;
  assign inst_valid    = (state_q == RET) && (src_q == SRC_INST);
  assign d_rdata_valid = (state_q == RET) && (src_q == SRC_DATA);
  assign inst_data     = inst_data_q;
  assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow the `ifdef MEM_ARB_RR_EN build.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_valid;
  logic [31:0] inst_addr;
  logic        inst_req_ready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_req_ready;
  logic        d_rdata_valid;
  logic        d_rdata_ready;
  logic [31:0] d_rdata;
  logic        m_req_valid;
  logic        m_req_ready;
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_resp_valid;
  logic        m_resp_ready;
  logic [31:0] m_resp_data;

  int checks = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_addr(inst_addr), .inst_req_ready(inst_req_ready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_req_ready(d_req_ready), .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready),
    .d_rdata(d_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr), .m_we(m_we),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_resp_valid(m_resp_valid),
    .m_resp_ready(m_resp_ready), .m_resp_data(m_resp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req_valid = 0; inst_addr = '0; inst_ready = 0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0; d_rdata_ready = 0;
    m_req_ready = 0; m_resp_valid = 0; m_resp_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    inst_req_valid = 1; d_read = 1;
    tick(); tick();
    checks++;
    if (inst_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_readies: got inst=%b d=%b, want 0 0", inst_req_ready, d_req_ready);
    end
    checks++;
    if ({inst_valid, d_rdata_valid, m_req_valid, m_resp_ready, m_we} !== 5'b0 ||
        m_addr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0 ||
        inst_data !== 32'h0 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got iv=%b dv=%b mrv=%b mrr=%b we=%b addr=%h wd=%h ws=%h id=%h dd=%h, want all 0",
               inst_valid, d_rdata_valid, m_req_valid, m_resp_ready, m_we, m_addr, m_wdata, m_wstrb,
               inst_data, d_rdata);
    end
    clear_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_fetch();
    inst_req_valid = 1; inst_addr = 32'h100; m_req_ready = 1;
    #1;
    checks++;
    if (inst_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL fetch_accept: got inst_rdy=%b d_rdy=%b, want 1 0", inst_req_ready, d_req_ready);
    end
    tick(); // cycle 0 accept
    inst_req_valid = 0; inst_addr = 32'hFFFF_FFFF;
    checks++;
    if (m_req_valid !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0 || m_wstrb !== 4'h0) begin
      failures++;
      $display("FAIL fetch_mreq: got v=%b addr=%h we=%b ws=%h, want 1 00000100 0 0",
               m_req_valid, m_addr, m_we, m_wstrb);
    end
    tick(); // cycle 1 handshake
    m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'h2402_0005;
    checks++;
    if (m_resp_ready !== 1'b1 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_mresp: got resp_rdy=%b iv=%b, want 1 0", m_resp_ready, inst_valid);
    end
    tick(); // cycle 2 response
    m_resp_valid = 0; m_resp_data = '0;
    checks++;
    if (inst_valid !== 1'b1 || inst_data !== 32'h2402_0005 || d_rdata_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_return: got iv=%b data=%h dv=%b, want 1 24020005 0",
               inst_valid, inst_data, d_rdata_valid);
    end
    inst_ready = 1;
    tick();
    inst_ready = 0;
    checks++;
    if (inst_valid !== 1'b0 || inst_data !== 32'h2402_0005) begin
      failures++;
      $display("FAIL fetch_hold: got iv=%b data=%h, want 0 24020005", inst_valid, inst_data);
    end
  endtask

  task automatic test_store();
    d_write = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; m_req_ready = 0;
    #1;
    checks++;
    if (d_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL store_accept: got d_rdy=%b, want 1", d_req_ready);
    end
    tick();
    d_write = 0; d_addr = 32'h1; d_wdata = 32'h0; d_wstrb = 4'hF;
    inst_req_valid = 1; d_read = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      checks++;
      if (m_req_valid !== 1'b1 || m_addr !== 32'h2000 || m_we !== 1'b1 ||
          m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'b0011 ||
          inst_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL store_stall[%0d]: got v=%b addr=%h we=%b wd=%h ws=%b irdy=%b drdy=%b, want 1 00002000 1 deadbeef 0011 0 0",
                 i, m_req_valid, m_addr, m_we, m_wdata, m_wstrb, inst_req_ready, d_req_ready);
      end
      tick();
    end
    inst_req_valid = 0; d_read = 0;
    m_req_ready = 1;
    tick(); // handshake
    m_req_ready = 0;
    checks++;
    if (m_req_valid !== 1'b0 || m_resp_ready !== 1'b0 || d_rdata_valid !== 1'b0) begin
      failures++;
      $display("FAIL store_done: got mrv=%b mrr=%b dv=%b, want 0 0 0", m_req_valid, m_resp_ready, d_rdata_valid);
    end
    d_read = 1; // IDLE again: next accept possible now
    #1;
    checks++;
    if (d_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL store_idle_again: got d_rdy=%b, want 1", d_req_ready);
    end
    d_read = 0;
    tick();
    checks++;
    if (d_rdata_valid !== 1'b0 || m_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL store_no_resp: got dv=%b mrv=%b, want 0 0", d_rdata_valid, m_req_valid);
    end
  endtask

  // Both channels request one read; checks the grant and completes the read.
  task automatic contest(input string name, input logic want_data, input logic [31:0] rdata);
    inst_req_valid = 1; inst_addr = 32'h400;
    d_read = 1; d_addr = 32'h800;
    m_req_ready = 1;
    #1;
    checks++;
    if (d_req_ready !== want_data || inst_req_ready !== !want_data) begin
      failures++;
      $display("FAIL %s_grant: got d_rdy=%b i_rdy=%b, want %b %b",
               name, d_req_ready, inst_req_ready, want_data, !want_data);
    end
    tick();
    inst_req_valid = 0; d_read = 0;
    checks++;
    if (m_addr !== (want_data ? 32'h800 : 32'h400)) begin
      failures++;
      $display("FAIL %s_addr: got %h, want %h", name, m_addr, want_data ? 32'h800 : 32'h400);
    end
    tick();
    m_req_ready = 0; m_resp_valid = 1; m_resp_data = rdata;
    tick();
    m_resp_valid = 0;
    checks++;
    if (d_rdata_valid !== want_data || inst_valid !== !want_data ||
        (want_data ? d_rdata : inst_data) !== rdata) begin
      failures++;
      $display("FAIL %s_return: got dv=%b iv=%b data=%h, want %b %b %h", name, d_rdata_valid,
               inst_valid, want_data ? d_rdata : inst_data, want_data, !want_data, rdata);
    end
    inst_ready = 1; d_rdata_ready = 1;
    tick();
    inst_ready = 0; d_rdata_ready = 0;
  endtask

  task automatic test_priority();
`ifdef MEM_ARB_RR_EN
    contest("contest1", 1'b0, 32'hAAAA_0001);
    contest("contest2", 1'b1, 32'hBBBB_0002);
`else
    contest("contest1", 1'b1, 32'hAAAA_0001);
    contest("contest2", 1'b1, 32'hBBBB_0002);
`endif
  endtask

  task automatic test_backpressure();
    d_read = 1; d_addr = 32'h40; m_req_ready = 1;
    tick();
    d_read = 0; m_req_ready = 1;
    tick();
    m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'hCAFE_F00D;
    tick();
    m_resp_valid = 0; m_resp_data = 32'h0;
    d_rdata_ready = 0; d_read = 1; inst_req_valid = 1;
    for (int unsigned i = 0; i < 5; i++) begin
      checks++;
      if (d_rdata_valid !== 1'b1 || d_rdata !== 32'hCAFE_F00D ||
          d_req_ready !== 1'b0 || inst_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got dv=%b data=%h drdy=%b irdy=%b, want 1 cafef00d 0 0",
                 i, d_rdata_valid, d_rdata, d_req_ready, inst_req_ready);
      end
      tick();
    end
    d_read = 0; inst_req_valid = 0;
    d_rdata_ready = 1;
    tick();
    d_rdata_ready = 0;
    checks++;
    if (d_rdata_valid !== 1'b0 || d_rdata !== 32'hCAFE_F00D || m_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got dv=%b data=%h mrv=%b, want 0 cafef00d 0", d_rdata_valid, d_rdata, m_req_valid);
    end
  endtask

  task automatic test_reset_mresp();
    d_read = 1; d_addr = 32'h80; m_req_ready = 1;
    tick();
    d_read = 0;
    tick(); // now in MRESP
    m_req_ready = 0;
    checks++;
    if (m_resp_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstm_in_mresp: got mrr=%b, want 1", m_resp_ready);
    end
    rst = 1;
    tick();
    rst = 0;
    m_resp_valid = 1; m_resp_data = 32'h1234;
    #1;
    checks++;
    if (m_resp_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstm_resp_ready: got %b, want 0", m_resp_ready);
    end
    tick(); tick();
    m_resp_valid = 0; m_resp_data = '0;
    checks++;
    if (d_rdata_valid !== 1'b0 || inst_valid !== 1'b0 || d_rdata !== 32'h0 || m_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstm_ignored: got dv=%b iv=%b data=%h mrv=%b, want 0 0 0 0",
               d_rdata_valid, inst_valid, d_rdata, m_req_valid);
    end
  endtask

  task automatic test_rw_both();
    d_read = 1; d_write = 1; d_addr = 32'h3000; d_wdata = 32'h5555_AAAA; d_wstrb = 4'hF;
    m_req_ready = 1;
    tick();
    d_read = 0; d_write = 0;
    checks++;
    if (m_req_valid !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h3000 ||
        m_wdata !== 32'h5555_AAAA || m_wstrb !== 4'hF) begin
      failures++;
      $display("FAIL rw_write: got v=%b we=%b addr=%h wd=%h ws=%h, want 1 1 00003000 5555aaaa f",
               m_req_valid, m_we, m_addr, m_wdata, m_wstrb);
    end
    tick();
    m_req_ready = 0;
    checks++;
    if (m_req_valid !== 1'b0 || m_resp_ready !== 1'b0) begin
      failures++;
      $display("FAIL rw_idle: got mrv=%b mrr=%b, want 0 0", m_req_valid, m_resp_ready);
    end
    tick();
    checks++;
    if (d_rdata_valid !== 1'b0 || m_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rw_no_read: got dv=%b mrv=%b, want 0 0", d_rdata_valid, m_req_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_backpressure();
    test_reset_mresp();
    test_rw_both();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
